// File: rtl/bennett_inst_dispatch.sv
// bennett_inst_dispatch
//
// Instruction dispatcher for an adiabatic datapath. It sits behind the Bennett
// square-ramp clock generator. Host instructions are queued in a small FIFO.
// On every rising edge of inst_flag, exactly one instruction (or a NOP bubble)
// is launched. It is then held on cur_inst for the whole forward/reverse ramp.
// The block also checks that inst_flag and mclk rises alternate. It pulses
// retire when the reverse ramp starts on a real instruction.
//
// Handshake (host side): a transfer happens in every cycle where
// in_valid && in_ready. in_ready depends only on the FIFO fill level
// (in_ready = !full). The host may hold in_valid high for as long as it likes.
// in_inst must stay stable while in_valid is high and in_ready is low.
//
// Ports:
//   clk          system clock (shared with the Bennett clock generator)
//   reset        asynchronous, active-high
//   in_valid     host instruction valid
//   in_ready     FIFO can accept an entry
//   in_inst      host instruction
//   inst_flag    instFlag from the generator (rising edge = dispatch)
//   mclk         Mclk from the generator (rising edge = reverse ramp begins)
//   cur_inst     instruction presented to the datapath
//   cur_valid    cur_inst is a real instruction, not a bubble
//   bubble       one-cycle pulse: a dispatch happened with the FIFO empty
//   retire       one-cycle pulse on an mclk rise while cur_valid is high
//   fifo_count   number of FIFO entries held
//   cycle_count  dispatches since reset (wraps at 2^16)
//   err_seq      sticky sequencing error
//   state        debug view of the sequencer: 0 = SYNC, 1 = FWD, 2 = REV
module bennett_inst_dispatch #(
   parameter int                 INST_W    = 16,
   parameter int                 DEPTH     = 4,
   parameter logic [INST_W-1:0]  NOP_VALUE = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [INST_W-1:0]         in_inst,
   input  logic                      inst_flag,
   input  logic                      mclk,
   output logic [INST_W-1:0]         cur_inst,
   output logic                      cur_valid,
   output logic                      bubble,
   output logic                      retire,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic [15:0]               cycle_count,
   output logic                      err_seq,
   output logic [1:0]                state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      SYNC = 2'd0,
      FWD  = 2'd1,
      REV  = 2'd2
   } state_t;

   state_t state_q, state_n;

   logic              flag_d, mclk_d;
   logic              flag_rise, mclk_rise;
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [INST_W-1:0] mem [DEPTH];
   logic              empty, full, push, pop;
   logic              err_set, retire_set;

   assign state     = state_q;
   assign flag_rise = inst_flag & ~flag_d;
   assign mclk_rise = mclk & ~mclk_d;

   assign empty    = (fifo_count == '0);
   assign full     = (fifo_count == CW'(DEPTH));
   assign in_ready = ~full;
   assign push     = in_valid & in_ready;
   // The pop looks only at the registered count. An entry pushed in the same
   // cycle as flag_rise is not visible yet, so that dispatch becomes a bubble.
   assign pop      = flag_rise & ~empty;

   // Storage needs no reset. Resetting the pointers and the count discards
   // whatever is left in the FIFO.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_inst;
   end

   // The sequencer only decides the phase, the error flag and the retire pulse.
   // Every flag_rise dispatches, whatever the current phase is.
   always_comb begin
      state_n    = state_q;
      err_set    = 1'b0;
      retire_set = 1'b0;
      // Both edges in one cycle are always illegal. Only the flag action applies.
      if (flag_rise && mclk_rise) err_set = 1'b1;
      case (state_q)
         SYNC: begin
            if (flag_rise) state_n = FWD;
         end
         FWD: begin
            if (flag_rise) begin
               err_set = 1'b1;
            end else if (mclk_rise) begin
               state_n    = REV;
               retire_set = cur_valid;
            end
         end
         REV: begin
            if (flag_rise)      state_n = FWD;
            else if (mclk_rise) err_set = 1'b1;
         end
         default: state_n = SYNC;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= SYNC;
         flag_d      <= 1'b0;
         mclk_d      <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_count  <= '0;
         cur_inst    <= NOP_VALUE;
         cur_valid   <= 1'b0;
         bubble      <= 1'b0;
         retire      <= 1'b0;
         cycle_count <= '0;
         err_seq     <= 1'b0;
      end else begin
         state_q <= state_n;
         flag_d  <= inst_flag;
         mclk_d  <= mclk;
         bubble  <= flag_rise & empty;
         retire  <= retire_set;
         if (err_set) err_seq <= 1'b1;

         if (flag_rise) begin
            cycle_count <= cycle_count + 16'd1;
            if (!empty) begin
               cur_inst  <= mem[rd_ptr];
               cur_valid <= 1'b1;
            end else begin
               cur_inst  <= NOP_VALUE;
               cur_valid <= 1'b0;
            end
         end

         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: doc/bennett_inst_dispatch.md
Name: bennett_inst_dispatch

Overview:
- Instruction dispatcher sitting directly downstream of the Bennett square-ramp clock generator.
- Buffers instructions from the host/fetch side in a small FIFO.
- Launches exactly one instruction per Bennett cycle, on the rising edge of the generator's instFlag. Holds it stable on its outputs for the whole forward/reverse ramp.
- Checks that instFlag and Mclk alternate legally, and issues a retire strobe when the reverse ramp begins.

Parameters:
- INST_W, 16, instruction width in bits.
- DEPTH, 4, FIFO depth in entries; power of two, minimum 2.
- NOP_VALUE, 0, instruction value driven on a bubble; INST_W bits.

Ports:
- clk, input, 1, system clock; same clock as the Bennett clock generator.
- reset, input, 1, asynchronous, active-high.
- in_valid, input, 1, host instruction valid.
- in_ready, output, 1, FIFO can accept; in_ready = !full.
- in_inst, input, INST_W, host instruction.
- inst_flag, input, 1, instFlag from the clock generator; the block rising-edge detects it.
- mclk, input, 1, Mclk from the clock generator; the block rising-edge detects it.
- cur_inst, output, INST_W, instruction presented to the adiabatic datapath.
- cur_valid, output, 1, cur_inst is a real instruction (not a bubble).
- bubble, output, 1, one-cycle pulse: a dispatch occurred with the FIFO empty.
- retire, output, 1, one-cycle pulse on the Mclk rise when cur_valid=1.
- fifo_count, output, clog2(DEPTH)+1, number of entries held.
- cycle_count, output, 16, number of dispatches since reset; wraps.
- err_seq, output, 1, sticky sequencing error.

Behaviour:
- Clock and reset: clock clk; reset is asynchronous, active-high.
- Reset values:
  - cur_inst=NOP_VALUE; cur_valid, bubble, retire, err_seq = 0.
  - fifo_count=0; cycle_count=0.
  - FIFO pointers = 0; edge registers flag_d and mclk_d = 0; state=SYNC.
- Reset asserted mid-cycle discards all FIFO contents and the held instruction immediately.
- Edge detect:
  - flag_rise = inst_flag & ~flag_d.
  - mclk_rise = mclk & ~mclk_d.
  - flag_d and mclk_d are registered every clk.
- FIFO:
  - push = in_valid & in_ready.
  - pop = flag_rise & (fifo_count != 0).
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - No bypass: a push into an empty FIFO in the same cycle as flag_rise is not dispatched. That dispatch is a bubble and the entry remains.
  - Pointers wrap modulo DEPTH.
- Dispatch (registered; outputs change at the clk edge where flag_rise is sampled true):
  - FIFO non-empty: cur_inst <= head, cur_valid <= 1, bubble <= 0.
  - FIFO empty: cur_inst <= NOP_VALUE, cur_valid <= 0, bubble <= 1 for one cycle.
  - Every dispatch: cycle_count <= cycle_count + 1, wrapping at 2^16.
  - cur_inst and cur_valid hold otherwise.
- State machine:
  - SYNC: after reset. mclk_rise is ignored. flag_rise -> dispatch, go to FWD.
  - FWD (forward ramp): mclk_rise -> REV; retire pulses one cycle if cur_valid. flag_rise -> err_seq <= 1, still dispatch, stay in FWD.
  - REV (reverse ramp): flag_rise -> dispatch, go to FWD. mclk_rise -> err_seq <= 1, no retire, stay in REV.
  - flag_rise and mclk_rise in the same cycle: err_seq <= 1. Then apply only the flag_rise action for the current state (SYNC/REV -> dispatch, FWD; FWD -> dispatch, stay FWD). No retire.
- err_seq clears only on reset.
- bubble and retire are never high for more than one consecutive cycle per event.

Test Plan:
- Reset, then push 0x1111, 0x2222. Pulse inst_flag one cycle -> next edge: cur_inst=0x1111, cur_valid=1, fifo_count=1, cycle_count=1, state FWD.
- Continue with mclk rise after 10 cycles -> retire pulses exactly one cycle, cur_inst still 0x1111. Next inst_flag pulse -> cur_inst=0x2222, cycle_count=2.
- FIFO empty, pulse inst_flag -> cur_inst=0x0000, cur_valid=0, bubble=1 for one cycle. Following mclk rise -> retire stays 0.
- Push 4 entries with DEPTH=4 -> in_ready=0, fifo_count=4. Push and inst_flag rise in the same cycle with count 4 -> push refused, pop occurs, fifo_count=3.
- Count=0, push and inst_flag rise in the same cycle -> bubble=1, fifo_count=1. Next inst_flag dispatches the pushed value.
- Two inst_flag pulses with no mclk between, or two mclk rises, or both rising the same cycle -> err_seq=1 and held until reset. Assert reset mid-FWD -> all outputs return to reset values asynchronously.
